// File: rtl/inst_stream_encoder.sv
// RV32I request -> instruction word encoder that streams words into IMEM through a small FIFO.
// Optional XOR checksum of written words is built only when INST_ENC_CHECKSUM_EN is defined.
module inst_stream_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_AW    = 14,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               finish,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_cls,
  input  logic [2:0]         req_func3,
  input  logic               req_alt,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_rs1,
  input  logic [4:0]         req_rs2,
  input  logic [31:0]        req_imm,
  input  logic               imem_ready,
  output logic [3:0]         imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IMEM_AW:0]   wr_count,
  output logic [31:0]        checksum
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IMEM_AW-1:0] BASE   = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW:0]   WC_MAX = '1;
  localparam logic [PW:0]        FULL_N = (PW+1)'(FIFO_DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       cnt_q;
  logic [IMEM_AW-1:0] nxt_addr_q, addr_q;
  logic              we_q;
  logic [31:0]       din_q;
  logic [IMEM_AW:0]  wrc_q;
  logic              err_q;

  req_t        rq;
  logic [31:0] enc_word;
  logic        enc_ill;
  logic [6:0]  f7_alt;
  logic        full, empty, accept, push, pop;

  assign rq = '{cls: req_cls, f3: req_func3, alt: req_alt, rd: req_rd,
                rs1: req_rs1, rs2: req_rs2, imm: req_imm};

  always_comb begin
    enc_word = '0;
    enc_ill  = 1'b0;
    f7_alt   = rq.alt ? 7'b0100000 : 7'b0000000;
    case (rq.cls)
      4'd0: begin
        enc_ill  = rq.alt && !(rq.f3 == 3'b000 || rq.f3 == 3'b101);
        enc_word = {f7_alt, rq.rs2, rq.rs1, rq.f3, rq.rd, OP_R};
      end
      4'd1: begin
        enc_ill = rq.alt && (rq.f3 != 3'b101);
        // shifts carry a 5-bit shamt plus funct7; everything else a 12-bit immediate
        if (rq.f3 == 3'b001 || rq.f3 == 3'b101)
          enc_word = {f7_alt, rq.imm[4:0], rq.rs1, rq.f3, rq.rd, OP_I};
        else
          enc_word = {rq.imm[11:0], rq.rs1, rq.f3, rq.rd, OP_I};
      end
      4'd2: begin
        enc_ill  = (rq.f3 == 3'b011) || (rq.f3 == 3'b110) || (rq.f3 == 3'b111);
        enc_word = {rq.imm[11:0], rq.rs1, rq.f3, rq.rd, OP_LOAD};
      end
      4'd3: begin
        enc_ill  = (rq.f3 > 3'b010);
        enc_word = {rq.imm[11:5], rq.rs2, rq.rs1, rq.f3, rq.imm[4:0], OP_STORE};
      end
      4'd4: begin
        enc_ill  = (rq.f3 == 3'b010) || (rq.f3 == 3'b011);
        enc_word = {rq.imm[12], rq.imm[10:5], rq.rs2, rq.rs1, rq.f3,
                    rq.imm[4:1], rq.imm[11], OP_BR};
      end
      4'd5: enc_word = {rq.imm[31:12], rq.rd, OP_LUI};
      4'd6: enc_word = {rq.imm[31:12], rq.rd, OP_AUIPC};
      4'd7: enc_word = {rq.imm[20], rq.imm[10:1], rq.imm[11], rq.imm[19:12], rq.rd, OP_JAL};
      4'd8: enc_word = {rq.imm[11:0], rq.rs1, 3'b000, rq.rd, OP_JALR};
      default: enc_ill = 1'b1;
    endcase
  end

  assign full   = (cnt_q == FULL_N);
  assign empty  = (cnt_q == '0);
  assign accept = req_valid && req_ready;
  assign push   = accept && !enc_ill;
  assign pop    = !empty && imem_ready && !start;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        req_ready = !full && !start;
        if (!start && finish) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (start) state_d = S_RUN;
        else if (empty && !we_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The word popped this cycle is presented on the registered write port next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      nxt_addr_q <= BASE;
      wrc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr_q     <= nxt_addr_q;
        din_q      <= fifo_q[rptr_q];
        nxt_addr_q <= nxt_addr_q + 1'b1;
        if (wrc_q != WC_MAX) wrc_q <= wrc_q + 1'b1;
      end
      if (start) begin
        nxt_addr_q <= BASE;
        wrc_q      <= '0;
        err_q      <= 1'b0;
      end else if (accept && enc_ill) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef INST_ENC_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     csum_q <= '0;
    else if (start) csum_q <= '0;
    else if (we_q)  csum_q <= csum_q ^ din_q;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign imem_we   = {4{we_q}};
  assign imem_addr = addr_q;
  assign imem_din  = din_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign wr_count  = wrc_q;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Bench for inst_stream_encoder: encoding vector table, multi-cycle corner sequences and a
// randomized run against a queue-based reference model.
module tb_inst_stream_encoder;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int BASE  = 3;
  localparam int WMAX  = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, finish = 1'b0, req_valid = 1'b0, req_alt = 1'b0;
  logic          req_ready, imem_ready = 1'b1;
  logic [3:0]    req_cls = '0;
  logic [2:0]    req_func3 = '0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0]   req_imm = '0;
  logic [3:0]    imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din, checksum;
  logic          busy, done, err;
  logic [AW:0]   wr_count;

  inst_stream_encoder #(.FIFO_DEPTH(DEPTH), .IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_cls(req_cls),
    .req_func3(req_func3), .req_alt(req_alt), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .imem_ready(imem_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din), .busy(busy),
    .done(done), .err(err), .wr_count(wr_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint fld(input longint v, input int hi, input int lo);
    return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder: builds the word as a sum of shifted fields.
  function automatic void ref_enc(input int cls, input int f3, input int alt, input int rd,
                                  input int rs1, input int rs2, input logic [31:0] imm,
                                  output logic [31:0] w, output bit ill);
    longint i = longint'(imm);
    longint f7 = alt ? 32 : 0;
    longint r = 0;
    ill = 0;
    case (cls)
      0: begin ill = alt && f3 != 0 && f3 != 5;
         r = f7 << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h33; end
      1: begin ill = alt && f3 != 5;
         if (f3 == 1 || f3 == 5) r = f7 << 25 | fld(i, 4, 0) << 20;
         else r = fld(i, 11, 0) << 20;
         r = r | rs1 << 15 | f3 << 12 | rd << 7 | 'h13; end
      2: begin ill = f3 == 3 || f3 >= 6;
         r = fld(i, 11, 0) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h03; end
      3: begin ill = f3 > 2;
         r = fld(i, 11, 5) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | fld(i, 4, 0) << 7 | 'h23; end
      4: begin ill = f3 == 2 || f3 == 3;
         r = fld(i, 12, 12) << 31 | fld(i, 10, 5) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
           | fld(i, 4, 1) << 8 | fld(i, 11, 11) << 7 | 'h63; end
      5: r = fld(i, 31, 12) << 12 | rd << 7 | 'h37;
      6: r = fld(i, 31, 12) << 12 | rd << 7 | 'h17;
      7: r = fld(i, 20, 20) << 31 | fld(i, 10, 1) << 21 | fld(i, 11, 11) << 20
           | fld(i, 19, 12) << 12 | rd << 7 | 'h6F;
      8: r = fld(i, 11, 0) << 20 | rs1 << 15 | rd << 7 | 'h67;
      default: ill = 1;
    endcase
    w = r[31:0];
  endfunction

  // Reference model: 0 idle, 1 run, 2 drain
  int          m_state = 0, m_wrc = 0, m_addr_nxt = BASE;
  logic [31:0] mq[$];
  bit          m_we = 0, m_err = 0, m_done = 0;
  int          m_addr = 0;
  logic [31:0] m_din = '0, m_csum = '0;
  bit          cur_rdy;

  function automatic bit m_ready();
    return m_state == 1 && mq.size() < DEPTH && !start;
  endfunction

  task automatic model_edge(input bit acc);
    bit pre_empty = (mq.size() == 0);
    bit pre_we = m_we;
    logic [31:0] w;
    bit ill;
    m_done = 0;
    if (start) begin
      mq.delete();
      m_addr_nxt = BASE; m_wrc = 0; m_err = 0; m_csum = '0; m_we = 0; m_state = 1;
    end else begin
`ifdef INST_ENC_CHECKSUM_EN
      if (pre_we) m_csum = m_csum ^ m_din;
`endif
      if (!pre_empty && imem_ready) begin
        m_we = 1; m_addr = m_addr_nxt; m_din = mq.pop_front();
        m_addr_nxt = (m_addr_nxt + 1) % (1 << AW);
        if (m_wrc < WMAX) m_wrc++;
      end else m_we = 0;
      if (acc) begin
        ref_enc(req_cls, req_func3, req_alt, req_rd, req_rs1, req_rs2, req_imm, w, ill);
        if (ill) m_err = 1; else mq.push_back(w);
      end
      if (m_state == 1 && finish) m_state = 2;
      else if (m_state == 2 && pre_empty && !pre_we) begin m_state = 0; m_done = 1; end
    end
  endtask

  task automatic cyc();
    bit acc;
    @(negedge clk);
    cur_rdy = req_ready;
    chk("req_ready", req_ready, m_ready());
    acc = req_valid && m_ready();
    @(posedge clk);
    model_edge(acc);
    #1;
    chk("imem_we", imem_we, m_we ? 4'hF : 4'h0);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_din", imem_din, m_din);
    chk("wr_count", wr_count, m_wrc);
    chk("err", err, m_err);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done);
    chk("checksum", checksum, m_csum);
  endtask

  task automatic set_req(input int cls, input int f3, input int alt, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
    req_cls = 4'(cls); req_func3 = 3'(f3); req_alt = alt[0];
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  typedef struct {
    int cls; int f3; int alt; int rd; int rs1; int rs2;
    logic [31:0] imm; logic [31:0] word; bit ill;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int n_acc, n_wr, n_done, at;
    bit seen;
    logic [31:0] got, w, x;
    bit ill;

    tbl[0]  = '{0, 0, 1, 3, 1, 2, 32'h0,        32'h402081B3, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 0, 32'h5,        32'h00500093, 0};
    tbl[2]  = '{3, 2, 0, 0, 1, 2, 32'h8,        32'h0020A423, 0};
    tbl[3]  = '{5, 0, 0, 5, 0, 0, 32'h12345000, 32'h123452B7, 0};
    tbl[4]  = '{4, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 0};
    tbl[5]  = '{7, 0, 0, 1, 0, 0, 32'h8,        32'h008000EF, 0};
    tbl[6]  = '{8, 3, 0, 0, 1, 0, 32'h0,        32'h00008067, 0};
    tbl[7]  = '{1, 5, 1, 2, 2, 0, 32'hFFFFFFE3, 32'h40315113, 0};
    tbl[8]  = '{6, 0, 0, 10, 0, 0, 32'hABCDE123, 32'hABCDE517, 0};
    tbl[9]  = '{2, 4, 0, 6, 7, 0, 32'h7FF,      32'h7FF3C303, 0};
    tbl[10] = '{0, 5, 1, 1, 2, 3, 32'h0,        32'h403150B3, 0};
    tbl[11] = '{1, 1, 0, 4, 4, 0, 32'hFFFFFFFF, 32'h01F21213, 0};
    tbl[12] = '{4, 1, 0, 0, 0, 0, 32'h800,      32'h000010E3, 0};
    tbl[13] = '{12, 0, 0, 1, 1, 1, 32'h0,       32'h0, 1};
    tbl[14] = '{2, 7, 0, 1, 1, 0, 32'h0,        32'h0, 1};
    tbl[15] = '{0, 1, 1, 1, 1, 1, 32'h0,        32'h0, 1};
    tbl[16] = '{1, 0, 1, 1, 1, 0, 32'h0,        32'h0, 1};
    tbl[17] = '{3, 3, 0, 0, 1, 2, 32'h0,        32'h0, 1};
    tbl[18] = '{4, 2, 0, 0, 1, 2, 32'h0,        32'h0, 1};

    #12;
    chk("rst_imem_we", imem_we, 4'h0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_din", imem_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_req_ready", req_ready, 0);
    #6 rst_n = 1'b1;
    repeat (2) cyc();

    // Encoding table: one request per fresh start, write expected two edges after accept
    foreach (tbl[k]) begin
      pulse_start();
      set_req(tbl[k].cls, tbl[k].f3, tbl[k].alt, tbl[k].rd, tbl[k].rs1, tbl[k].rs2, tbl[k].imm);
      req_valid = 1'b1; cyc(); req_valid = 1'b0;
      seen = 0; got = '0; at = -1;
      for (int c = 0; c < 3; c++) begin
        cyc();
        if (imem_we == 4'hF && !seen) begin seen = 1; got = imem_din; at = c; end
      end
      if (!tbl[k].ill) begin
        chk($sformatf("tbl%0d_din", k), got, tbl[k].word);
        chk($sformatf("tbl%0d_latency", k), at, 0);
      end else begin
        chk($sformatf("tbl%0d_err", k), err, 1);
        chk($sformatf("tbl%0d_nowrite", k), seen, 0);
      end
    end

    // Backpressure: memory stalled, five offered, four fit
    pulse_start();
    imem_ready = 1'b0; req_valid = 1'b1; n_acc = 0; n_wr = 0;
    for (int c = 0; c < 5; c++) begin
      set_req(1, 0, 0, c + 1, 0, 0, 32'(c + 10));
      cyc();
      if (cur_rdy) n_acc++;
      if (imem_we != 4'h0) n_wr++;
    end
    chk("bp_accepted", n_acc, 4);
    chk("bp_ready_low", cur_rdy, 0);
    chk("bp_nowrite", n_wr, 0);
    imem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (cur_rdy && req_valid) begin n_acc++; req_valid = 1'b0; end
      if (imem_we == 4'hF) n_wr++;
    end
    chk("bp_fifth_accepted", n_acc, 5);
    chk("bp_writes", n_wr, 5);

    // Illegal requests set sticky err without writing; start clears it
    pulse_start();
    set_req(12, 0, 0, 1, 1, 1, 32'h0); req_valid = 1'b1; cyc();
    set_req(2, 7, 0, 1, 1, 0, 32'h0); cyc(); req_valid = 1'b0;
    repeat (3) cyc();
    chk("ill_err", err, 1);
    chk("ill_wr_count", wr_count, 0);
    pulse_start();
    chk("ill_err_cleared", err, 0);
    set_req(5, 0, 0, 1, 0, 0, 32'hFFFFF000); req_valid = 1'b1; cyc(); req_valid = 1'b0;
    cyc();
    chk("restart_addr", imem_addr, BASE);

    // Finish drains three queued words, then done pulses once
    pulse_start();
    imem_ready = 1'b0; x = '0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(0, c, 0, c + 1, c + 2, c + 3, 32'h0);
      ref_enc(0, c, 0, c + 1, c + 2, c + 3, 32'h0, w, ill);
      x = x ^ w;
      cyc();
    end
    req_valid = 1'b0; finish = 1'b1; imem_ready = 1'b1; cyc(); finish = 1'b0;
    n_wr = (imem_we == 4'hF) ? 1 : 0; n_done = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (imem_we == 4'hF) n_wr++;
      if (done) n_done++;
    end
    chk("drain_writes", n_wr, 3);
    chk("drain_done_pulses", n_done, 1);
    chk("drain_busy", busy, 0);
`ifdef INST_ENC_CHECKSUM_EN
    chk("drain_checksum", checksum, x);
`else
    chk("drain_checksum_off", checksum, 0);
`endif

    // Start and finish together: start wins, stays in RUN
    pulse_start();
    start = 1'b1; finish = 1'b1; cyc(); start = 1'b0; finish = 1'b0;
    cyc();
    chk("start_beats_finish", req_ready, 1);

    // Long stream: address wraps, wr_count saturates
    pulse_start();
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      set_req(5, 0, 0, c % 32, 0, 0, 32'($urandom));
      cyc();
    end
    req_valid = 1'b0;
    repeat (4) cyc();
    chk("wr_count_sat", wr_count, WMAX);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int r = $urandom % 20;
      start  = (m_state == 0) ? ($urandom % 3 == 0) : ($urandom % 100 == 0);
      finish = ($urandom % 40 == 0);
      req_valid  = ($urandom % 4 != 0);
      imem_ready = ($urandom % 4 != 0);
      set_req(r < 18 ? r % 9 : 9 + $urandom % 7, $urandom % 8, $urandom % 4 == 0,
              $urandom % 32, $urandom % 32, $urandom % 32, $urandom);
      cyc();
    end
    start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
